// File: rtl/capture_pos_gen_if.sv
// Video stream bundle between the input receiver, capture_pos_gen and the line buffer writer.
// The master side drives the incoming pixel stream and consumes the positioned stream.
// The slave side (capture_pos_gen) does the opposite.
interface capture_pos_gen_if #(
    parameter int unsigned H_CNT_W = 12
);
    logic [7:0]         R_i;
    logic [7:0]         G_i;
    logic [7:0]         B_i;
    logic               HSYNC_i;
    logic               VSYNC_i;
    logic               DE_i;
    logic [7:0]         R_o;
    logic [7:0]         G_o;
    logic [7:0]         B_o;
    logic               DE_o;
    logic [10:0]        xpos_o;
    logic [10:0]        ypos_o;
    logic               FID_o;
    logic               interlaced_o;
    logic               frame_change_o;
    logic [H_CNT_W-1:0] h_total_o;

    modport master (
        output R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i,
        input  R_o, G_o, B_o, DE_o, xpos_o, ypos_o, FID_o, interlaced_o, frame_change_o,
               h_total_o
    );

    modport slave (
        input  R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i,
        output R_o, G_o, B_o, DE_o, xpos_o, ypos_o, FID_o, interlaced_o, frame_change_o,
               h_total_o
    );
endinterface

// File: rtl/capture_pos_gen.sv
// Capture-side timing front end: measures line length, detects field parity / interlacing and
// turns the raw RGB + sync stream into an xpos/ypos/DE/FID stream for the line buffer writer.
// Pipeline: input register, counter state, output register (sample at edge N -> outputs at N+2).
// Optional macro CAP_DE_MODE_EN: derive the active window from the source DE_i instead of the
// hv_in_config / hv_in_config2 window settings.
module capture_pos_gen #(
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned H_CNT_W  = 12,
    parameter int unsigned V_CNT_W  = 11
) (
    input  logic             PCLK_CAP_i,
    input  logic             reset_i,
    input  logic [31:0]      hv_in_config,
    input  logic [31:0]      hv_in_config2,
    capture_pos_gen_if.slave vid
);
    logic               r_hs_in, r_vs_in, r_hs_prev, r_vs_prev;
    logic [23:0]        r_rgb_in, r_rgb_mid, r_rgb_o;
    logic [H_CNT_W-1:0] r_h_cnt, r_h_total, r_h_total_o;
    logic [V_CNT_W-1:0] r_v_cnt;
    logic               r_v_defer, r_fid_raw, r_fid, r_interlaced;
    logic               r_de_o, r_fid_o, r_il_o, r_fc_o;
    logic [10:0]        r_xpos_o, r_ypos_o;

    logic               w_hs_lead, w_vs_lead, w_vs_odd, w_il;
    logic [H_CNT_W-1:0] w_h_inc;
    logic [V_CNT_W-1:0] w_v_inc;
    logic               w_de;
    logic [10:0]        w_xpos, w_ypos;
    logic               w_unused_cfg;

    // Register inputs; syncs are normalised to active-high and delayed once for edge detect
    always_ff @(posedge PCLK_CAP_i) begin
        if (reset_i) begin
            r_hs_in   <= 1'b0;
            r_vs_in   <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_rgb_in  <= '0;
            r_rgb_mid <= '0;
        end else begin
            r_hs_in   <= (vid.HSYNC_i == SYNC_POL);
            r_vs_in   <= (vid.VSYNC_i == SYNC_POL);
            r_hs_prev <= r_hs_in;
            r_vs_prev <= r_vs_in;
            r_rgb_in  <= {vid.R_i, vid.G_i, vid.B_i};
            r_rgb_mid <= r_rgb_in;
        end
    end

    assign w_hs_lead = r_hs_in & ~r_hs_prev;
    assign w_vs_lead = r_vs_in & ~r_vs_prev;
    assign w_h_inc   = (&r_h_cnt) ? r_h_cnt : r_h_cnt + H_CNT_W'(1);
    assign w_v_inc   = (&r_v_cnt) ? r_v_cnt : r_v_cnt + V_CNT_W'(1);
    // Vsync in the first half of a line (or together with hsync) marks an odd field
    assign w_vs_odd  = w_hs_lead || (r_h_cnt < (r_h_total >> 1));
    assign w_il      = (w_vs_odd != r_fid_raw);

    // Line/field counters, line length measurement and field parity tracking
    always_ff @(posedge PCLK_CAP_i) begin
        if (reset_i) begin
            r_h_cnt      <= '0;
            r_h_total    <= '0;
            r_v_cnt      <= '0;
            r_v_defer    <= 1'b0;
            r_fid_raw    <= 1'b1;
            r_fid        <= 1'b1;
            r_interlaced <= 1'b0;
        end else begin
            if (w_hs_lead) begin
                r_h_cnt   <= '0;
                r_h_total <= w_h_inc;
                // An even-field vsync defers its v reset to this hsync, which then does not count
                if (w_vs_lead || r_v_defer) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= w_v_inc;
                end
            end else begin
                r_h_cnt <= w_h_inc;
                if (w_vs_lead && w_vs_odd) begin
                    r_v_cnt <= '0;
                end
            end

            if (w_vs_lead) begin
                r_v_defer    <= ~w_vs_odd;
                r_fid_raw    <= w_vs_odd;
                r_interlaced <= w_il;
                r_fid        <= w_il ? w_vs_odd : 1'b1;
            end else if (w_hs_lead) begin
                r_v_defer <= 1'b0;
            end
        end
    end

`ifdef CAP_DE_MODE_EN
    logic        r_de_in, r_de_prev, r_de_mid;
    logic [10:0] r_x, r_y;

    assign w_unused_cfg = ^{hv_in_config, hv_in_config2};

    // Capture source DE alongside the syncs
    always_ff @(posedge PCLK_CAP_i) begin
        if (reset_i) begin
            r_de_in   <= 1'b0;
            r_de_prev <= 1'b0;
        end else begin
            r_de_in   <= vid.DE_i;
            r_de_prev <= r_de_in;
        end
    end

    // x restarts on every DE rise; y restarts per field and steps after each DE line
    always_ff @(posedge PCLK_CAP_i) begin
        if (reset_i) begin
            r_de_mid <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_de_mid <= r_de_in;
            if (r_de_in && !r_de_prev) begin
                r_x <= '0;
            end else if (r_de_in) begin
                r_x <= r_x + 11'd1;
            end
            if (w_vs_lead) begin
                r_y <= '0;
            end else if (!r_de_in && r_de_prev) begin
                r_y <= r_y + 11'd1;
            end
        end
    end

    assign w_de   = r_de_mid;
    assign w_xpos = r_x;
    assign w_ypos = r_y;
`else
    localparam int unsigned HXW = H_CNT_W + 1;
    localparam int unsigned VXW = V_CNT_W + 1;

    logic [HXW-1:0] w_hstart, w_hend, w_hcnt_x;
    logic [VXW-1:0] w_vstart, w_vend, w_vcnt_x;
    logic           w_line_act;

    assign w_unused_cfg = ^{vid.DE_i, hv_in_config[31:28], hv_in_config2[31:24]};

    // One extra bit keeps start+active from wrapping below the counter range
    assign w_hstart   = HXW'(hv_in_config[27:20]) + HXW'(hv_in_config[19:11]);
    assign w_hend     = w_hstart + HXW'(hv_in_config[10:0]);
    assign w_vstart   = VXW'(hv_in_config2[23:20]) + VXW'(hv_in_config2[19:11]);
    assign w_vend     = w_vstart + VXW'(hv_in_config2[10:0]);
    assign w_hcnt_x   = HXW'(r_h_cnt);
    assign w_vcnt_x   = VXW'(r_v_cnt);
    assign w_line_act = (w_vcnt_x >= w_vstart) && (w_vcnt_x < w_vend);
    assign w_de       = w_line_act && (w_hcnt_x >= w_hstart) && (w_hcnt_x < w_hend);
    assign w_xpos     = 11'(w_hcnt_x - w_hstart);
    assign w_ypos     = w_line_act ? 11'(w_vcnt_x - w_vstart) : 11'd0;
`endif

    // Output register: everything aligned to the pixel held in r_rgb_mid
    always_ff @(posedge PCLK_CAP_i) begin
        if (reset_i) begin
            r_rgb_o     <= '0;
            r_de_o      <= 1'b0;
            r_xpos_o    <= '0;
            r_ypos_o    <= '0;
            r_fid_o     <= 1'b1;
            r_il_o      <= 1'b0;
            r_fc_o      <= 1'b0;
            r_h_total_o <= '0;
        end else begin
            r_rgb_o     <= r_rgb_mid;
            r_de_o      <= w_de;
            r_xpos_o    <= w_de ? w_xpos : 11'd0;
            r_ypos_o    <= w_ypos;
            r_fid_o     <= r_fid;
            r_il_o      <= r_interlaced;
            r_fc_o      <= (r_v_cnt == '0);
            r_h_total_o <= r_h_total;
        end
    end

    assign vid.R_o            = r_rgb_o[23:16];
    assign vid.G_o            = r_rgb_o[15:8];
    assign vid.B_o            = r_rgb_o[7:0];
    assign vid.DE_o           = r_de_o;
    assign vid.xpos_o         = r_xpos_o;
    assign vid.ypos_o         = r_ypos_o;
    assign vid.FID_o          = r_fid_o;
    assign vid.interlaced_o   = r_il_o;
    assign vid.frame_change_o = r_fc_o;
    assign vid.h_total_o      = r_h_total_o;
endmodule

// File: tb/tb_capture_pos_gen.sv
// Scoreboard bench for capture_pos_gen using a scaled-down timing (32 x 14 per field).
// The stimulus pushes one expected entry per active pixel and one expected frame_change length
// per field; a negedge monitor pops and compares whenever the DUT presents them.
module tb_capture_pos_gen;
    localparam int   H_TOT   = 32;
    localparam int   V_TOT   = 14;
    localparam int   H_SYNC  = 4;
    localparam int   V_SYNC  = 2;
    localparam int   EVEN_VS = 20;  // even-field vsync starts well past mid-line
    localparam logic POL     = 1'b0;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        fid;
        logic        il;
        logic [11:0] ht;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg1, cfg2;
    exp_t        exp_q[$];
    int          fc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          drv_cyc = 0;
    int          de_cycles = 0;
    int          fc_run = 0;
    bit          mon_en = 1'b0;

    capture_pos_gen_if vif ();

    capture_pos_gen #(
        .SYNC_POL (POL),
        .H_CNT_W  (12),
        .V_CNT_W  (11)
    ) dut (
        .PCLK_CAP_i    (clk),
        .reset_i       (rst),
        .hv_in_config  (cfg1),
        .hv_in_config2 (cfg2),
        .vid           (vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one entry per DE_o cycle and one length per frame_change pulse
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (vif.DE_o === 1'b1) begin
                de_cycles++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL de_unexpected: DE_o high x=%0d y=%0d with nothing expected",
                             vif.xpos_o, vif.ypos_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({vif.xpos_o, vif.ypos_o, vif.R_o, vif.G_o, vif.B_o, vif.FID_o,
                         vif.interlaced_o, vif.h_total_o} !==
                        {e.x, e.y, e.r, e.g, e.b, e.fid, e.il, e.ht}) begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d rgb=%h_%h_%h fid=%b il=%b ht=%0d expected x=%0d y=%0d rgb=%h_%h_%h fid=%b il=%b ht=%0d",
                                 vif.xpos_o, vif.ypos_o, vif.R_o, vif.G_o, vif.B_o, vif.FID_o,
                                 vif.interlaced_o, vif.h_total_o, e.x, e.y, e.r, e.g, e.b,
                                 e.fid, e.il, e.ht);
                    end
                end
            end else begin
                check("xpos_idle", vif.xpos_o, 0);
            end
            if (vif.frame_change_o === 1'b1) begin
                fc_run++;
            end else if (fc_run > 0) begin
                if (fc_q.size() == 0) begin
                    check("fc_unexpected", fc_run, 0);
                end else begin
                    check("fc_len", fc_run, fc_q.pop_front());
                end
                fc_run = 0;
            end
        end
    end

    // Drive one pixel at the negedge; driving a pixel also releases reset
    task automatic drive(input bit hs, input bit vs, input bit de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        rst         = 1'b0;
        vif.HSYNC_i = hs ~^ POL;
        vif.VSYNC_i = vs ~^ POL;
        vif.DE_i    = de;
        vif.R_i     = r;
        vif.G_i     = g;
        vif.B_i     = b;
    endtask

    task automatic check_reset_values();
        check("rst_de", vif.DE_o, 0);
        check("rst_xpos", vif.xpos_o, 0);
        check("rst_ypos", vif.ypos_o, 0);
        check("rst_fid", vif.FID_o, 1);
        check("rst_il", vif.interlaced_o, 0);
        check("rst_fc", vif.frame_change_o, 0);
        check("rst_htotal", vif.h_total_o, 0);
        check("rst_rgb", {vif.R_o, vif.G_o, vif.B_o}, 0);
    endtask

    // Reset mid-stream: the two pixels still in the input/counter stages are dropped
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].tag >= drv_cyc - 2) begin
            void'(exp_q.pop_back());
        end
        @(negedge clk);
        check_reset_values();
        repeat (3) @(negedge clk);
    endtask

    task automatic frame(input bit even_f, input bit exp_fid, input bit exp_il, input bit first,
                         input bit chk_sat, input bit abort);
        int   hstart, hend, vstart, vend, vc, idx;
        bit   hs, vs, win;
        exp_t e;
        hstart = int'(cfg1[27:20]) + int'(cfg1[19:11]);
        hend   = hstart + int'(cfg1[10:0]);
        vstart = int'(cfg2[23:20]) + int'(cfg2[19:11]);
        vend   = vstart + int'(cfg2[10:0]);
        // Straight after reset v_cnt is already 0, so the first pulse is two cycles longer
        fc_q.push_back(first ? H_TOT + 2 : H_TOT);
        for (int l = 0; l < V_TOT; l++) begin
            for (int p = 0; p < H_TOT; p++) begin
                idx = l * H_TOT + p;
                hs  = (p < H_SYNC);
                vs  = even_f ? (idx >= EVEN_VS && idx < EVEN_VS + V_SYNC * H_TOT) : (l < V_SYNC);
                vc  = even_f ? l - 1 : l;
                win = (p >= hstart) && (p < hend) && (vc >= vstart) && (vc < vend);
                drive(hs, vs, win, 8'(p), 8'(l), 8'(p ^ l) ^ {even_f, 7'd0});
                if (win) begin
                    e.x   = 11'(p - hstart);
                    e.y   = 11'(vc - vstart);
                    e.r   = 8'(p);
                    e.g   = 8'(l);
                    e.b   = 8'(p ^ l) ^ {even_f, 7'd0};
                    e.fid = exp_fid;
                    e.il  = exp_il;
                    e.ht  = 12'(H_TOT);
                    e.tag = drv_cyc;
                    exp_q.push_back(e);
                end
                drv_cyc++;
                if (chk_sat && l == 0 && p == 10) begin
                    check("h_total_sat", vif.h_total_o, 4095);
                end
                if (abort && l == 7 && p == 15) begin
                    do_reset();
                    return;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int snap;
        rst         = 1'b1;
        cfg1        = {4'd0, 8'd4, 9'd6, 11'd16};
        cfg2        = {8'd0, 4'd2, 9'd3, 11'd6};
        vif.HSYNC_i = ~POL;
        vif.VSYNC_i = ~POL;
        vif.DE_i    = 1'b0;
        vif.R_i     = '0;
        vif.G_i     = '0;
        vif.B_i     = '0;
        repeat (3) @(negedge clk);
        check_reset_values();
        mon_en = 1'b1;

        // Progressive, then interlaced, then back to progressive
        frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Window change takes effect without latching
        cfg1 = {4'd0, 8'd4, 9'd3, 11'd8};
        cfg2 = {8'd0, 4'd2, 9'd1, 11'd3};
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero active width: no DE at all
        cfg1 = {4'd0, 8'd4, 9'd6, 11'd0};
        cfg2 = {8'd0, 4'd2, 9'd3, 11'd6};
        snap = de_cycles;
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("de_hact0", de_cycles - snap, 0);

        // Sync loss long enough to overflow a wrapping counter, then relock
        cfg1 = {4'd0, 8'd4, 9'd6, 11'd16};
        snap = de_cycles;
        for (int i = 0; i < 5000; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'(i));
        end
        check("de_sync_loss", de_cycles - snap, 0);
        check("h_total_pre", vif.h_total_o, H_TOT);
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of an active line, then a clean restart
        frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (8) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("fc_q_empty", fc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
